hazard_scoreboard: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core: stall, flush and forwarding selects for fetch, decode, execute and memory stages.
- Keeps its own shadow pipeline of register tags (E, M, W), advanced under the same stall/flush it issues, so it needs only decode-stage fields plus memory handshake.
- Drives Forward_A_D/Forward_B_D of decode_stage, the execute forwarding muxes and the pipeline-register enables/clears.
- Sequences variable-latency data-memory accesses with a wait FSM, a timeout and a stall counter.

---
 rtl/hazard_if.sv | 45 ++++
 rtl/hazard_scoreboard.sv | 132 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Decode-stage fields and memory handshake in, stall/flush/forward controls out.
// The master side drives the decode fields; the scoreboard sits on the slave side.
interface hazard_if #(
  parameter int op_width  = 5,
  parameter int cnt_width = 16
);
  logic [op_width-1:0]  rsd;
  logic [op_width-1:0]  rtd;
  logic [op_width-1:0]  dst_d;
  logic                 reg_write_d;
  logic                 mem_to_reg_d;
  logic                 mem_write_d;
  logic                 branch_d;
  logic [1:0]           pc_src_d;
  logic                 mem_ready;
  logic                 stall_f;
  logic                 stall_d;
  logic                 stall_e;
  logic                 stall_m;
  logic                 flush_d;
  logic                 flush_e;
  logic                 flush_w;
  logic                 forward_a_d;
  logic                 forward_b_d;
  logic [1:0]           forward_a_e;
  logic [1:0]           forward_b_e;
  logic                 mem_timeout;
  logic [cnt_width-1:0] stall_cycles;

  modport master (
    output rsd, rtd, dst_d, reg_write_d, mem_to_reg_d, mem_write_d,
           branch_d, pc_src_d, mem_ready,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
           forward_a_d, forward_b_d, forward_a_e, forward_b_e,
           mem_timeout, stall_cycles
  );

  modport slave (
    input  rsd, rtd, dst_d, reg_write_d, mem_to_reg_d, mem_write_d,
           branch_d, pc_src_d, mem_ready,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
           forward_a_d, forward_b_d, forward_a_e, forward_b_e,
           mem_timeout, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard controller for a 5-stage MIPS pipeline: shadow register-tag pipeline,
// forwarding selects, load/branch interlocks and variable-latency memory wait.
//   state    | meaning
//   RUN      | normal issue; memory access in M completes this cycle or we enter wait
//   MEM_WAIT | M-stage access outstanding, whole pipeline frozen
//   ERROR    | memory never answered; frozen until reset
module hazard_scoreboard #(
  parameter int op_width       = 5,
  parameter int timeout_cycles = 64,
  parameter int cnt_width      = 16
) (
  input logic     clk,
  input logic     reset,
  hazard_if.slave hz
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  localparam int wc_width = $clog2(timeout_cycles + 1);

  state_t               state;
  logic [wc_width-1:0]  wait_cnt;
  logic                 timeout_q;
  logic [cnt_width-1:0] stall_cnt;

  logic [op_width-1:0]  rs_e, rt_e, dst_e, dst_m, dst_w;
  logic                 rw_e, m2r_e, mw_e, rw_m, m2r_m, mw_m, rw_w;

  logic mem_acc_m, mem_stall, lw_stall, br_stall, hz_stall;

  function automatic logic match(input logic [op_width-1:0] x,
                                 input logic [op_width-1:0] y,
                                 input logic v);
    return v && (x != '0) && (x == y);
  endfunction

  always_comb begin
    mem_acc_m = m2r_m | mw_m;
    // once the access completes in MEM_WAIT the stall drops the same cycle
    mem_stall = (state == ERROR) ||
                (state == MEM_WAIT && !hz.mem_ready) ||
                (state == RUN && mem_acc_m && !hz.mem_ready);
    lw_stall  = m2r_e && (dst_e != '0) && (dst_e == hz.rsd || dst_e == hz.rtd);
    br_stall  = hz.branch_d &&
                (match(hz.rsd, dst_e, rw_e)  || match(hz.rtd, dst_e, rw_e) ||
                 match(hz.rsd, dst_m, m2r_m) || match(hz.rtd, dst_m, m2r_m));
    hz_stall  = lw_stall | br_stall;
  end

  assign hz.stall_f = mem_stall | hz_stall;
  assign hz.stall_d = mem_stall | hz_stall;
  assign hz.stall_e = mem_stall;
  assign hz.stall_m = mem_stall;
  assign hz.flush_w = mem_stall;
  assign hz.flush_e = !mem_stall && hz_stall;
  assign hz.flush_d = !mem_stall && !hz_stall && (|hz.pc_src_d);

  assign hz.forward_a_d = match(hz.rsd, dst_m, rw_m);
  assign hz.forward_b_d = match(hz.rtd, dst_m, rw_m);
  assign hz.forward_a_e = match(rs_e, dst_m, rw_m) ? 2'b10 :
                          match(rs_e, dst_w, rw_w) ? 2'b01 : 2'b00;
  assign hz.forward_b_e = match(rt_e, dst_m, rw_m) ? 2'b10 :
                          match(rt_e, dst_w, rw_w) ? 2'b01 : 2'b00;

  assign hz.mem_timeout  = timeout_q;
  assign hz.stall_cycles = stall_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_acc_m && !hz.mem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= wc_width'(1);
          end
        end
        MEM_WAIT: begin
          if (hz.mem_ready) begin
            state <= RUN;
          end else if (wait_cnt == wc_width'(timeout_cycles)) begin
            state     <= ERROR;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + wc_width'(1);
          end
        end
        ERROR:   state <= ERROR;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (hz.stall_d && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + cnt_width'(1);
    end
  end

  // shadow tag pipeline follows exactly the stall/flush pattern issued above
  always_ff @(posedge clk) begin
    if (!reset) begin
      rs_e <= '0; rt_e <= '0; dst_e <= '0; rw_e <= 1'b0; m2r_e <= 1'b0; mw_e <= 1'b0;
      dst_m <= '0; rw_m <= 1'b0; m2r_m <= 1'b0; mw_m <= 1'b0;
      dst_w <= '0; rw_w <= 1'b0;
    end else if (mem_stall) begin
      dst_w <= '0;
      rw_w  <= 1'b0;
    end else begin
      if (hz_stall) begin
        rs_e <= '0; rt_e <= '0; dst_e <= '0; rw_e <= 1'b0; m2r_e <= 1'b0; mw_e <= 1'b0;
      end else begin
        rs_e  <= hz.rsd;
        rt_e  <= hz.rtd;
        dst_e <= hz.dst_d;
        rw_e  <= hz.reg_write_d;
        m2r_e <= hz.mem_to_reg_d;
        mw_e  <= hz.mem_write_d;
      end
      dst_m <= dst_e;
      rw_m  <= rw_e;
      m2r_m <= m2r_e;
      mw_m  <= mw_e;
      dst_w <= dst_m;
      rw_w  <= rw_m;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed vector bench for hazard_scoreboard: table of per-cycle decode inputs
// with hand-derived outputs, then timeout, saturation and reset sequences.
module tb_hazard_scoreboard;
  localparam int ow = 5;
  localparam int cw = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_if #(.op_width(ow), .cnt_width(cw)) hz ();

  hazard_scoreboard #(.op_width(ow), .timeout_cycles(4), .cnt_width(cw)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  // {stall_f,d,e,m, flush_d,e,w, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e}
  logic [12:0] obs;
  assign obs = {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m,
                hz.flush_d, hz.flush_e, hz.flush_w,
                hz.forward_a_d, hz.forward_b_d, hz.forward_a_e, hz.forward_b_e};

  typedef struct {
    logic [4:0]  rs, rt, dst;
    logic [3:0]  flg;   // {reg_write, mem_to_reg, mem_write, branch}
    logic [1:0]  pc;
    logic        rdy;
    logic [12:0] exp;
    logic [3:0]  sc;
  } vec_t;

  localparam logic [3:0] NO = 4'b0000, RW = 4'b1000, LW = 4'b1100, BR = 4'b0001;
  localparam logic [12:0] Z = 13'b0;
  localparam logic [12:0] LWST = 13'b1100_010_00_00_00;
  localparam logic [12:0] FRZ  = 13'b1111_001_00_00_00;

  int total = 0;
  int bad   = 0;
  vec_t tbl[39];

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] dst, input logic [3:0] flg,
                              input logic [1:0] pc, input logic rdy,
                              input logic [12:0] exp, input logic [3:0] sc);
    vec_t v;
    v.rs = rs; v.rt = rt; v.dst = dst; v.flg = flg;
    v.pc = pc; v.rdy = rdy; v.exp = exp; v.sc = sc;
    return v;
  endfunction

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] dst, input logic [3:0] flg,
                       input logic [1:0] pc, input logic rdy);
    hz.rsd = rs; hz.rtd = rt; hz.dst_d = dst;
    hz.reg_write_d = flg[3]; hz.mem_to_reg_d = flg[2];
    hz.mem_write_d = flg[1]; hz.branch_d = flg[0];
    hz.pc_src_d = pc; hz.mem_ready = rdy;
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = mk(1, 2, 3,  RW, 0, 0, Z, 0);
    tbl[1]  = mk(3, 1, 4,  RW, 0, 0, Z, 0);
    tbl[2]  = mk(3, 0, 5,  RW, 0, 0, 13'b0000_000_10_10_00, 0);
    tbl[3]  = mk(1, 1, 0,  RW, 0, 0, 13'b0000_000_00_01_00, 0);
    tbl[4]  = mk(0, 0, 6,  RW, 0, 0, Z, 0);
    tbl[5]  = mk(0, 0, 0,  NO, 0, 0, Z, 0);
    tbl[6]  = mk(0, 0, 0,  NO, 0, 0, Z, 0);
    tbl[7]  = mk(1, 5, 5,  LW, 0, 0, Z, 0);
    tbl[8]  = mk(5, 1, 6,  RW, 0, 0, LWST, 0);
    tbl[9]  = mk(5, 1, 6,  RW, 0, 1, 13'b0000_000_10_00_00, 1);
    tbl[10] = mk(0, 0, 0,  NO, 0, 0, 13'b0000_000_00_01_00, 1);
    tbl[11] = mk(1, 2, 4,  RW, 0, 0, Z, 1);
    tbl[12] = mk(4, 2, 0,  BR, 1, 0, LWST, 1);
    tbl[13] = mk(4, 2, 0,  BR, 1, 0, 13'b0000_100_10_00_00, 2);
    tbl[14] = mk(0, 0, 0,  NO, 0, 0, 13'b0000_000_00_01_00, 2);
    tbl[15] = mk(0, 0, 0,  NO, 0, 0, Z, 2);
    tbl[16] = mk(0, 0, 0,  NO, 2, 0, 13'b0000_100_00_00_00, 2);
    tbl[17] = mk(1, 2, 7,  RW, 0, 0, Z, 2);
    tbl[18] = mk(0, 7, 8,  RW, 0, 0, Z, 2);
    tbl[19] = mk(0, 0, 0,  NO, 0, 0, 13'b0000_000_00_00_10, 2);
    tbl[20] = mk(1, 1, 9,  RW, 0, 0, Z, 2);
    tbl[21] = mk(1, 1, 9,  RW, 0, 0, Z, 2);
    tbl[22] = mk(9, 9, 10, RW, 0, 0, 13'b0000_000_11_00_00, 2);
    tbl[23] = mk(0, 0, 0,  NO, 0, 0, 13'b0000_000_00_10_10, 2);
    tbl[24] = mk(0, 0, 0,  NO, 0, 0, Z, 2);
    tbl[25] = mk(1, 11, 11, LW, 0, 0, Z, 2);
    tbl[26] = mk(11, 0, 0, BR, 0, 0, LWST, 2);
    tbl[27] = mk(11, 0, 0, BR, 0, 1, 13'b1100_010_10_00_00, 3);
    tbl[28] = mk(11, 0, 0, BR, 0, 1, Z, 4);
    tbl[29] = mk(0, 0, 0,  NO, 0, 0, Z, 4);
    tbl[30] = mk(0, 0, 0,  NO, 0, 0, Z, 4);
    // load in M waits 3 cycles while a load-use hazard also sits in E/D
    tbl[31] = mk(1, 12, 12, LW, 0, 0, Z, 4);
    tbl[32] = mk(1, 13, 13, LW, 0, 0, Z, 4);
    tbl[33] = mk(13, 12, 14, RW, 0, 0, 13'b1111_001_01_00_00, 4);
    tbl[34] = mk(13, 12, 14, RW, 0, 0, 13'b1111_001_01_00_00, 5);
    tbl[35] = mk(13, 12, 14, RW, 0, 0, 13'b1111_001_01_00_00, 6);
    tbl[36] = mk(13, 12, 14, RW, 0, 1, 13'b1100_010_01_00_00, 7);
    tbl[37] = mk(13, 12, 14, RW, 0, 1, 13'b0000_000_10_00_00, 8);
    tbl[38] = mk(0, 0, 0,  NO, 0, 0, 13'b0000_000_00_01_00, 8);

    reset = 1'b0;
    drive(0, 0, 0, NO, 0, 0);
    tick();
    tick();
    chk("reset_outs", 16'(obs), 16'(Z));
    chk("reset_cnt", 16'(hz.stall_cycles), 16'd0);
    chk("reset_tmo", 16'(hz.mem_timeout), 16'd0);
    reset = 1'b1;

    for (int i = 0; i < 39; i++) begin
      drive(tbl[i].rs, tbl[i].rt, tbl[i].dst, tbl[i].flg, tbl[i].pc, tbl[i].rdy);
      #2;
      chk($sformatf("vec%0d_outs", i), 16'(obs), 16'(tbl[i].exp));
      chk($sformatf("vec%0d_cnt", i), 16'(hz.stall_cycles), 16'(tbl[i].sc));
      chk($sformatf("vec%0d_tmo", i), 16'(hz.mem_timeout), 16'd0);
      tick();
    end

    // timeout: load reaches M and memory never answers
    drive(1, 15, 15, LW, 0, 0);
    tick();
    drive(0, 0, 0, NO, 0, 0);
    tick();
    for (int k = 1; k <= 12; k++) begin
      hz.mem_ready = (k >= 8);
      #2;
      chk($sformatf("tmo%0d_outs", k), 16'(obs), 16'(FRZ));
      chk($sformatf("tmo%0d_flag", k), 16'(hz.mem_timeout), (k <= 5) ? 16'd0 : 16'd1);
      tick();
    end
    chk("cnt_saturate", 16'(hz.stall_cycles), 16'd15);

    reset = 1'b0;
    hz.mem_ready = 1'b0;
    tick();
    chk("err_reset_outs", 16'(obs), 16'(Z));
    chk("err_reset_tmo", 16'(hz.mem_timeout), 16'd0);
    chk("err_reset_cnt", 16'(hz.stall_cycles), 16'd0);
    reset = 1'b1;
    tick();
    chk("post_reset_outs", 16'(obs), 16'(Z));

    // reset while in MEM_WAIT
    drive(1, 16, 16, LW, 0, 0);
    tick();
    drive(0, 0, 0, NO, 0, 0);
    tick();
    tick();
    chk("wait_outs", 16'(obs), 16'(FRZ));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("wait_reset_outs", 16'(obs), 16'(Z));
    tick();
    chk("wait_reset_run", 16'(obs), 16'(Z));
    chk("wait_reset_cnt", 16'(hz.stall_cycles), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
